// File: rtl/alu32_pkg.sv
// ----------------------------------------------------------------------------
// alu32_pkg
// Shared definitions for the ALU32 field packing path:
//   - field select encodings (low / high part of the operand)
//   - width decode for the 5-bit field length (0 encodes a full 32-bit field)
//   - packer FSM state type
// ----------------------------------------------------------------------------
package alu32_pkg;

   localparam int DATA_W = 32;
   localparam int ACC_W  = 64;

   // Control bit 31: which end of the operand the field is cut from.
   localparam logic SEL_LOW  = 1'b1;
   localparam logic SEL_HIGH = 1'b0;

   // ACCUM: collecting fields. DRAIN: a flush is pending, input is blocked
   // until the final partial word has been handed over.
   typedef enum logic {
      ACCUM = 1'b0,
      DRAIN = 1'b1
   } pack_state_t;

   // Field length n in 1..31 is literal; n = 0 stands for 32.
   function automatic logic [5:0] decode_width(input logic [4:0] n);
      return (n == 5'd0) ? 6'd32 : {1'b0, n};
   endfunction

endpackage

// File: rtl/field_select32.sv
// ----------------------------------------------------------------------------
// field_select32
// Purely combinational field extractor. Cuts a w-bit field out of a 32-bit
// operand, from either the low or the high end, and returns it right-aligned
// and zero-extended together with its width.
// Ports:
//   data  in  32  source operand
//   ctrl  in  32  [31] select (SEL_LOW/SEL_HIGH), [4:0] length (0 = 32)
//   f     out 32  extracted field, right-aligned, upper bits zero
//   w     out  6  field width, 1..32
// ----------------------------------------------------------------------------
module field_select32
   import alu32_pkg::*;
(
   input  logic [31:0] data,
   input  logic [31:0] ctrl,
   output logic [31:0] f,
   output logic [5:0]  w
);

   logic [31:0] low_mask;

   // Bits [30:5] of the control word carry no meaning for this unit.
   logic unused_ctrl_bits;
   assign unused_ctrl_bits = ^ctrl[30:5];

   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so
      // no path through the block leaves a signal unassigned (no latch).
      w        = decode_width(ctrl[4:0]);
      low_mask = '1;
      f        = data;

      // A 32-bit field keeps the full mask; shifting by 32 is avoided.
      if (w != 6'd32) begin
         low_mask = (32'd1 << w) - 32'd1;
      end

      if (ctrl[31] == SEL_LOW) begin
         f = data & low_mask;
      end else begin
         // High select: the logical right shift brings data[31:32-w] down to
         // bit 0 and fills the top with zeros.
         f = data >> (6'd32 - w);
      end
   end

endmodule

// File: rtl/field_packer32.sv
// ----------------------------------------------------------------------------
// field_packer32
// Streaming bit-field packer. Fields cut from 32-bit operands are appended
// LSB-first into a 64-bit accumulator; each time 32 bits are available a
// dense word is offered downstream. A field tagged with In_Flush closes the
// packet: the remaining bits are emitted zero-padded with Out_Last set.
// Ports:
//   CLK        in   1  clock, rising edge
//   RST_N      in   1  asynchronous active-low reset
//   In_Valid   in   1  field present
//   In_Ready   out  1  packer accepts a field this cycle
//   In_Data    in  32  source operand
//   In_Ctrl    in  32  [31] 1 = low bits, 0 = high bits; [4:0] length, 0 = 32
//   In_Flush   in   1  field is the last of its packet (qualified by In_Valid)
//   Out_Valid  out  1  word available
//   Out_Ready  in   1  consumer takes the word
//   Out_Data   out 32  packed word, unused upper bits zero
//   Out_Last   out  1  final word of a flushed packet
//   Out_Bits   out  6  valid bits in Out_Data when Out_Last, otherwise 32
// ----------------------------------------------------------------------------
module field_packer32
   import alu32_pkg::*;
(
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        In_Valid,
   output logic        In_Ready,
   input  logic [31:0] In_Data,
   input  logic [31:0] In_Ctrl,
   input  logic        In_Flush,
   output logic        Out_Valid,
   input  logic        Out_Ready,
   output logic [31:0] Out_Data,
   output logic        Out_Last,
   output logic [5:0]  Out_Bits
);

   pack_state_t state, state_next;

   // Accumulator: bits at index >= fill are kept at zero, so appending a new
   // field is a plain OR at offset fill.
   logic [ACC_W-1:0] acc, acc_next, acc_shift;
   logic [5:0]       fill, fill_next, fill_shift;

   logic [31:0] field;
   logic [5:0]  field_w;
   logic        in_fire;
   logic        out_fire;

   field_select32 u_select (
      .data (In_Data),
      .ctrl (In_Ctrl),
      .f    (field),
      .w    (field_w)
   );

   assign in_fire  = In_Valid && In_Ready;
   assign out_fire = Out_Valid && Out_Ready;

   // ---------------------------------------------------------------- state reg
   // NOTE: clocked blocks use non-blocking assignments only, so every register
   // samples the values from before the edge regardless of block ordering.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= ACCUM;
      end else begin
         state <= state_next;
      end
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      state_next = state;
      case (state)
         ACCUM:   if (in_fire && In_Flush)  state_next = DRAIN;
         DRAIN:   if (out_fire && Out_Last) state_next = ACCUM;
         default: state_next = ACCUM;
      endcase
   end

   // ------------------------------------------------------------------ outputs
   // Out_Valid depends on registered state only; In_Ready looks at Out_Ready
   // so a full word can be drained and a new field taken in the same cycle.
   always_comb begin
      Out_Valid = (fill >= 6'd32) || (state == DRAIN);
      Out_Last  = (state == DRAIN) && (fill <= 6'd32);
      Out_Data  = acc[31:0];
      Out_Bits  = Out_Last ? fill : 6'd32;
      In_Ready  = (state == ACCUM) && ((fill < 6'd32) || Out_Ready);
   end

   // ----------------------------------------------------------------- datapath
   // Output shift first, then append. In ACCUM an input transfer implies the
   // post-shift fill is below 32, so fill_next tops out at 31 + 32 = 63.
   always_comb begin
      acc_shift  = acc;
      fill_shift = fill;
      if (out_fire) begin
         acc_shift  = {32'd0, acc[63:32]};
         fill_shift = (fill >= 6'd32) ? (fill - 6'd32) : 6'd0;
      end

      acc_next  = acc_shift;
      fill_next = fill_shift;
      if (in_fire) begin
         acc_next  = acc_shift | ({32'd0, field} << fill_shift);
         fill_next = fill_shift + field_w;
      end
   end

   // NOTE: the accumulator is cleared on reset as well as fill; the zero-above-
   // fill invariant the append relies on must hold from the first field.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         acc  <= '0;
         fill <= '0;
      end else begin
         acc  <= acc_next;
         fill <= fill_next;
      end
   end

endmodule
